// File: rtl/axis_pkt_checker_pkg.sv
// axis_pkt_checker_pkg: shared error codes, tuser layout and generator defaults
package axis_pkt_checker_pkg;
    typedef enum logic [2:0] {ERR_NONE, ERR_DATA, ERR_LEN, ERR_KEEP, ERR_HDR} err_e;
    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_e;
    localparam int LEN_HI = 79;
    localparam int LEN_LO = 64;
    localparam int MAC_HI = 63;
    localparam int MAC_LO = 16;
    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 0;
    localparam logic [47:0] DEF_MAC = 48'h0102_0304_0506;
    localparam logic [15:0] DEF_TYPE = 16'h0800;
    function automatic logic [3:0] popcnt8(input logic [7:0] k);
        logic [3:0] n;
        n = '0;
        for (int b = 0; b < 8; b++) n = n + 4'(k[b]);
        return n;
    endfunction
    // Last-beat keep must be ones packed from the MSB: its inverse is a low-side mask
    function automatic logic keep_ok(input logic [7:0] k);
        logic [7:0] inv;
        inv = ~k;
        return (k != 8'd0) && ((inv & (inv + 8'd1)) == 8'd0);
    endfunction
endpackage

// File: rtl/axis_pkt_checker_if.sv
// axis_pkt_checker_if: 64-bit AXIS beat with 80-bit sideband
interface axis_pkt_checker_if;
    logic [63:0] tdata;
    logic [79:0] tuser;
    logic [7:0] tkeep;
    logic tlast;
    logic tvalid;
    logic tready;
    modport master(output tdata, tuser, tkeep, tlast, tvalid, input tready);
    modport slave(input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_ready_stall.sv
// axis_ready_stall: tready source with optional one-in-N periodic stall
module axis_ready_stall #(
    parameter int P_STALL_PERIOD = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_ready
);
    localparam int W = P_STALL_PERIOD > 2 ? $clog2(P_STALL_PERIOD) : 1;
    logic rdy;
    logic [W-1:0] cnt;
    // Release ready after reset and run the free mod-N stall counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdy <= 1'b0;
            cnt <= '0;
        end else begin
            rdy <= 1'b1;
            cnt <= (cnt == W'(P_STALL_PERIOD - 1)) ? '0 : cnt + W'(1);
        end
    end
    assign o_ready = rdy && !(P_STALL_PERIOD >= 2 && cnt == W'(P_STALL_PERIOD - 1));
endmodule

// File: rtl/axis_pkt_checker.sv
// axis_pkt_checker: checks generator-pattern AXIS packets and keeps packet/error/byte counters
module axis_pkt_checker
    import axis_pkt_checker_pkg::*;
#(
    parameter logic [47:0] P_EXP_MAC = DEF_MAC,
    parameter logic [15:0] P_EXP_TYPE = DEF_TYPE,
    parameter int P_STALL_PERIOD = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    axis_pkt_checker_if.slave s_axis,
    output logic [15:0] o_pkt_cnt,
    output logic [15:0] o_err_cnt,
    output logic [31:0] o_byte_cnt,
    output logic o_pkt_done,
    output logic o_pkt_err,
    output logic [2:0] o_err_code
);
    state_e state, state_n;
    err_e err_q, err_n, err_c, beat_err;
    logic [15:0] bcnt, bcnt_n, len_q, len_n, len_c, idx;
    logic [79:0] user_q, user_n, ref_c;
    logic [15:0] pc_n, ec_n;
    logic [31:0] bytes_n;
    logic done_n, perr_n;
    logic [2:0] code_n;
    logic ready, first, acc, end_pkt, e_data, e_hdr, e_len, e_keep, fatal;
    axis_ready_stall #(.P_STALL_PERIOD(P_STALL_PERIOD)) u_stall (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .o_ready(ready)
    );
    assign s_axis.tready = ready;
    // Beat checks, first-error tracking, next state and next counter/status values
    always_comb begin
        first = state == IDLE || state == DONE;
        acc = s_axis.tvalid && ready;
        end_pkt = acc && s_axis.tlast;
        idx = first ? 16'd0 : bcnt;
        len_c = first ? s_axis.tuser[LEN_HI:LEN_LO] : len_q;
        ref_c = first ? s_axis.tuser : user_q;
        e_data = s_axis.tdata != {4{idx}};
        e_hdr = s_axis.tuser != ref_c || s_axis.tuser[MAC_HI:MAC_LO] != P_EXP_MAC
              || s_axis.tuser[TYPE_HI:TYPE_LO] != P_EXP_TYPE || len_c == 16'd0;
        e_len = len_c != 16'd0 && (s_axis.tlast ? idx < len_c - 16'd1 : idx == len_c - 16'd1);
        e_keep = s_axis.tlast ? !keep_ok(s_axis.tkeep) : s_axis.tkeep != 8'hFF;
        fatal = !s_axis.tlast && (len_c == 16'd0 || idx == len_c - 16'd1);
        beat_err = e_data ? ERR_DATA : e_len ? ERR_LEN : e_keep ? ERR_KEEP : e_hdr ? ERR_HDR : ERR_NONE;
        err_c = (state == DRAIN || (!first && err_q != ERR_NONE)) ? err_q : beat_err;
        state_n = !acc ? (state == DONE ? IDLE : state)
                : s_axis.tlast ? DONE : (state == DRAIN || fatal) ? DRAIN : RECV;
        bcnt_n = !acc ? bcnt : first ? 16'd1 : bcnt == 16'hFFFF ? bcnt : bcnt + 16'd1;
        len_n = acc && first ? s_axis.tuser[LEN_HI:LEN_LO] : len_q;
        user_n = acc && first ? s_axis.tuser : user_q;
        err_n = acc ? err_c : err_q;
        done_n = end_pkt;
        code_n = end_pkt ? err_c : o_err_code;
        perr_n = end_pkt ? err_c != ERR_NONE : o_pkt_err;
        bytes_n = end_pkt ? {13'd0, idx, 3'd0} + 32'(popcnt8(s_axis.tkeep)) : o_byte_cnt;
        pc_n = end_pkt && err_c == ERR_NONE && o_pkt_cnt != 16'hFFFF ? o_pkt_cnt + 16'd1 : o_pkt_cnt;
        ec_n = end_pkt && err_c != ERR_NONE && o_err_cnt != 16'hFFFF ? o_err_cnt + 16'd1 : o_err_cnt;
    end
    // State, packet context and observation registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            bcnt <= '0;
            len_q <= '0;
            user_q <= '0;
            err_q <= ERR_NONE;
            o_pkt_done <= 1'b0;
            o_pkt_err <= 1'b0;
            o_err_code <= '0;
            o_byte_cnt <= '0;
            o_pkt_cnt <= '0;
            o_err_cnt <= '0;
        end else begin
            state <= state_n;
            bcnt <= bcnt_n;
            len_q <= len_n;
            user_q <= user_n;
            err_q <= err_n;
            o_pkt_done <= done_n;
            o_pkt_err <= perr_n;
            o_err_code <= code_n;
            o_byte_cnt <= bytes_n;
            o_pkt_cnt <= pc_n;
            o_err_cnt <= ec_n;
        end
    end
endmodule

// File: tb/tb_axis_pkt_checker.sv
// tb_axis_pkt_checker: scoreboard bench for the packet checker, with and without stall
module tb_axis_pkt_checker;
    import axis_pkt_checker_pkg::*;
    typedef struct {
        logic [2:0] code;
        logic [31:0] bytes;
        logic [15:0] pc;
        logic [15:0] ec;
    } exp_t;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic [15:0] pc0_o, ec0_o, pc1_o, ec1_o;
    logic [31:0] by0_o, by1_o;
    logic dn0_o, dn1_o, pe0_o, pe1_o;
    logic [2:0] cd0_o, cd1_o;
    logic al0, al1, seen1;
    exp_t q0[$];
    exp_t q1[$];
    int tests = 0;
    int fails = 0;
    int pc0 = 0, ec0 = 0, pc1 = 0, ec1 = 0;
    int cyc1 = 0, last_low = -1, lows = 0;
    axis_pkt_checker_if if0();
    axis_pkt_checker_if if1();
    always #5 clk = ~clk;
    axis_pkt_checker u_dut0 (
        .i_clk(clk), .i_rst(rst0), .s_axis(if0),
        .o_pkt_cnt(pc0_o), .o_err_cnt(ec0_o), .o_byte_cnt(by0_o),
        .o_pkt_done(dn0_o), .o_pkt_err(pe0_o), .o_err_code(cd0_o)
    );
    axis_pkt_checker #(.P_STALL_PERIOD(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst1), .s_axis(if1),
        .o_pkt_cnt(pc1_o), .o_err_cnt(ec1_o), .o_byte_cnt(by1_o),
        .o_pkt_done(dn1_o), .o_pkt_err(pe1_o), .o_err_code(cd1_o)
    );
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic drive(int sel, logic [63:0] d, logic [79:0] u, logic [7:0] k, logic l, logic v);
        if (sel == 0) begin
            if0.tdata = d; if0.tuser = u; if0.tkeep = k; if0.tlast = l; if0.tvalid = v;
        end else begin
            if1.tdata = d; if1.tuser = u; if1.tkeep = k; if1.tlast = l; if1.tvalid = v;
        end
    endtask
    task automatic beat(int sel, logic [63:0] d, logic [79:0] u, logic [7:0] k, logic l);
        logic r;
        drive(sel, d, u, k, l, 1'b1);
        for (int t = 0; t < 50; t++) begin
            r = sel == 0 ? if0.tready : if1.tready;
            @(negedge clk);
            if (r) return;
        end
        tests++;
        fails++;
        $display("FAIL beat_timeout%0d: got no tready expected acceptance within 50 cycles", sel);
    endtask
    task automatic pkt(int sel, int nb, int len, logic [15:0] typ, logic [7:0] lk, int bad,
                       logic [2:0] code, logic [31:0] bytes);
        exp_t e;
        if (sel == 0) begin
            if (code == 3'd0) pc0++; else ec0++;
            e.pc = 16'(pc0); e.ec = 16'(ec0);
        end else begin
            if (code == 3'd0) pc1++; else ec1++;
            e.pc = 16'(pc1); e.ec = 16'(ec1);
        end
        e.code = code;
        e.bytes = bytes;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        for (int i = 0; i < nb; i++)
            beat(sel, i == bad ? 64'h0 : {4{16'(i)}}, {16'(len), DEF_MAC, typ},
                 i == nb - 1 ? lk : 8'hFF, i == nb - 1);
    endtask
    task automatic cmp(string tag, exp_t e, logic [2:0] cd, logic pe, logic [31:0] by,
                       logic [15:0] pc, logic [15:0] ec);
        chk({tag, "_code"}, 32'(cd), 32'(e.code));
        chk({tag, "_perr"}, 32'(pe), 32'(e.code != 3'd0));
        chk({tag, "_bytes"}, by, e.bytes);
        chk({tag, "_pktcnt"}, 32'(pc), 32'(e.pc));
        chk({tag, "_errcnt"}, 32'(ec), 32'(e.ec));
    endtask
    task automatic chk_reset0(string tag);
        chk({tag, "_tready"}, 32'(if0.tready), 0);
        chk({tag, "_pktcnt"}, 32'(pc0_o), 0);
        chk({tag, "_errcnt"}, 32'(ec0_o), 0);
        chk({tag, "_bytes"}, by0_o, 0);
        chk({tag, "_done"}, 32'(dn0_o), 0);
        chk({tag, "_perr"}, 32'(pe0_o), 0);
        chk({tag, "_code"}, 32'(cd0_o), 0);
    endtask
    // Record tlast acceptances so the monitors can check the one-cycle done latency
    always @(posedge clk) begin
        al0 <= if0.tvalid && if0.tready && if0.tlast;
        al1 <= if1.tvalid && if1.tready && if1.tlast;
    end
    // Monitor for the unstalled checker
    always @(negedge clk) if (!rst0) begin
        if (dn0_o || al0) chk("done_latency0", 32'(dn0_o), 32'(al0));
        if (dn0_o) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done0: got o_pkt_done expected none");
            end else cmp("pkt0", q0.pop_front(), cd0_o, pe0_o, by0_o, pc0_o, ec0_o);
        end
    end
    // Monitor for the stalled checker, including the stall spacing
    always @(negedge clk) if (!rst1) begin
        if (dn1_o || al1) chk("done_latency4", 32'(dn1_o), 32'(al1));
        if (dn1_o) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done4: got o_pkt_done expected none");
            end else cmp("pkt4", q1.pop_front(), cd1_o, pe1_o, by1_o, pc1_o, ec1_o);
        end
        if (!if1.tready && seen1) begin
            lows++;
            if (last_low >= 0) chk("stall_gap", 32'(cyc1 - last_low), 4);
            last_low = cyc1;
        end
        if (if1.tready) seen1 = 1'b1;
        cyc1++;
    end
    task automatic run0();
        drive(0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk_reset0("rst0");
        rst0 = 1'b0;
        @(negedge clk);
        chk("tready_release0", 32'(if0.tready), 1);
        pkt(0, 186, 186, DEF_TYPE, 8'hFF, -1, 3'd0, 1488);
        pkt(0, 186, 186, DEF_TYPE, 8'hFE, -1, 3'd0, 1487);
        pkt(0, 186, 186, DEF_TYPE, 8'hF0, -1, 3'd0, 1484);
        pkt(0, 186, 186, DEF_TYPE, 8'h80, -1, 3'd0, 1481);
        pkt(0, 186, 186, DEF_TYPE, 8'hFF, 10, 3'd1, 1488);
        pkt(0, 186, 186, DEF_TYPE, 8'hFF, -1, 3'd0, 1488);
        pkt(0, 100, 186, DEF_TYPE, 8'hFF, -1, 3'd2, 800);
        pkt(0, 201, 186, DEF_TYPE, 8'hFF, -1, 3'd2, 1608);
        pkt(0, 186, 186, DEF_TYPE, 8'hB0, -1, 3'd3, 1483);
        pkt(0, 186, 186, 16'h86DD, 8'hFF, -1, 3'd4, 1488);
        pkt(0, 1, 1, DEF_TYPE, 8'hC0, -1, 3'd0, 2);
        pkt(0, 1, 0, DEF_TYPE, 8'hFF, -1, 3'd4, 8);
        drive(0, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 50; i++) beat(0, {4{16'(i)}}, {16'd186, DEF_MAC, DEF_TYPE}, 8'hFF, 1'b0);
        drive(0, '0, '0, '0, 1'b0, 1'b0);
        rst0 = 1'b1;
        @(negedge clk);
        chk_reset0("midrst0");
        pc0 = 0;
        ec0 = 0;
        rst0 = 1'b0;
        @(negedge clk);
        pkt(0, 186, 186, DEF_TYPE, 8'hFF, -1, 3'd0, 1488);
        drive(0, '0, '0, '0, 1'b0, 1'b0);
    endtask
    task automatic run1();
        drive(1, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst4_tready", 32'(if1.tready), 0);
        rst1 = 1'b0;
        @(negedge clk);
        pkt(1, 186, 186, DEF_TYPE, 8'hFF, -1, 3'd0, 1488);
        pkt(1, 186, 186, DEF_TYPE, 8'hF0, -1, 3'd0, 1484);
        drive(1, '0, '0, '0, 1'b0, 1'b0);
    endtask
    initial begin
        seen1 = 1'b0;
        fork
            run0();
            run1();
        join
        for (int t = 0; t < 20 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge clk);
        chk("pending_pkts", 32'(q0.size() + q1.size()), 0);
        chk("stall_seen", 32'(lows >= 10), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of stimulus expected completion by 500000");
        $fatal(1);
    end
endmodule
